// File: rtl/param_control_unit.sv
// param_control_unit
// Multicycle control unit for the 16-bit CPU. It sequences fetch, decode and
// execute for the instruction held in IR and drives the PC, data memory,
// register file and ALU select lines of the datapath. It supports a
// configurable load latency, branch on the ALU zero flag, a PC-load jump,
// a HALT state that can be resumed, and selectable illegal-opcode handling.
//
// Parameters:
//   LOAD_LAT        data-memory read latency in cycles (1..15)
//   PC_W            program counter width (>= 8)
//   ALU_S_W         ALU select width (>= 3)
//   TRAP_ON_ILLEGAL 0: skip illegal opcodes, 1: enter HALT on them
//
// Ports:
//   i_clock      sole clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_ir         current instruction
//   i_alu_z      ALU zero flag
//   i_resume     leaves HALT
//   o_pc_clr     clear PC
//   o_pc_ld      load PC from o_pc_addr
//   o_pc_addr    jump target, IR[7:0] zero-extended
//   o_pc_ic      increment PC
//   o_ir_ld      load IR from instruction memory
//   o_d_addr     data memory address
//   o_d_wr       data memory write enable
//   o_rf_s       register-file write mux (1 = memory, 0 = ALU)
//   o_rf_w_en    register-file write enable
//   o_rf_a_addr  register-file read port A address
//   o_rf_b_addr  register-file read port B address
//   o_rf_w_addr  register-file write address
//   o_alu_s      ALU function select
//   o_halted     high while in HALT
//   o_illegal    one-cycle pulse in DECODE on an undefined opcode
//   o_state      current state encoding (debug)
module param_control_unit #(
    parameter int unsigned LOAD_LAT        = 1,
    parameter int unsigned PC_W            = 8,
    parameter int unsigned ALU_S_W         = 4,
    parameter bit          TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [15:0]        i_ir,
    input  logic               i_alu_z,
    input  logic               i_resume,
    output logic               o_pc_clr,
    output logic               o_pc_ld,
    output logic [PC_W-1:0]    o_pc_addr,
    output logic               o_pc_ic,
    output logic               o_ir_ld,
    output logic [7:0]         o_d_addr,
    output logic               o_d_wr,
    output logic               o_rf_s,
    output logic               o_rf_w_en,
    output logic [3:0]         o_rf_a_addr,
    output logic [3:0]         o_rf_b_addr,
    output logic [3:0]         o_rf_w_addr,
    output logic [ALU_S_W-1:0] o_alu_s,
    output logic               o_halted,
    output logic               o_illegal,
    output logic [3:0]         o_state
);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_LOAD    = 4'd3,
        S_LOAD_WB = 4'd4,
        S_STORE   = 4'd5,
        S_ALU     = 4'd6,
        S_JMP     = 4'd7,
        S_BRZ     = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_JMP   = 4'h7,
        OP_BRZ   = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4
    } alu_op_t;

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;
    logic [3:0]           w_op;

    logic                 w_pc_clr;
    logic                 w_pc_ld;
    logic                 w_pc_ic;
    logic                 w_ir_ld;
    logic [7:0]           w_d_addr;
    logic                 w_d_wr;
    logic                 w_rf_s;
    logic                 w_rf_w_en;
    logic [3:0]           w_rf_a_addr;
    logic [3:0]           w_rf_b_addr;
    logic [3:0]           w_rf_w_addr;
    logic [ALU_S_W-1:0]   w_alu_s;
    logic                 w_halted;
    logic                 w_illegal;

    assign w_op = i_ir[15:12];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_pc_clr    = 1'b0;
        w_pc_ld     = 1'b0;
        w_pc_ic     = 1'b0;
        w_ir_ld     = 1'b0;
        w_d_addr    = '0;
        w_d_wr      = 1'b0;
        w_rf_s      = 1'b0;
        w_rf_w_en   = 1'b0;
        w_rf_a_addr = '0;
        w_rf_b_addr = '0;
        w_rf_w_addr = '0;
        w_alu_s     = '0;
        w_halted    = 1'b0;
        w_illegal   = 1'b0;

        case (r_state)
            S_INIT: begin
                w_pc_clr = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                w_ir_ld = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                w_pc_ic = 1'b1;
                case (w_op)
                    OP_NOOP:  w_next = S_FETCH;
                    OP_LOAD: begin
                        w_next     = S_LOAD;
                        w_cnt_next = LAT_M1;
                    end
                    OP_STORE: w_next = S_STORE;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = S_ALU;
                    OP_JMP:   w_next = S_JMP;
                    OP_BRZ:   w_next = S_BRZ;
                    OP_HALT:  w_next = S_HALT;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_LOAD, S_LOAD_WB: begin
                w_d_addr    = i_ir[11:4];
                w_rf_s      = 1'b1;
                w_rf_w_addr = i_ir[3:0];
                if (r_state == S_LOAD_WB) begin
                    w_rf_w_en = 1'b1;
                    w_next    = S_FETCH;
                end else if (r_cnt == 4'd0) begin
                    w_next = S_LOAD_WB;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_STORE: begin
                w_d_addr    = i_ir[7:0];
                w_rf_a_addr = i_ir[11:8];
                w_d_wr      = 1'b1;
                w_next      = S_FETCH;
            end
            S_ALU: begin
                w_rf_a_addr = i_ir[11:8];
                w_rf_b_addr = i_ir[7:4];
                w_rf_w_addr = i_ir[3:0];
                w_rf_w_en   = 1'b1;
                case (w_op)
                    OP_ADD:  w_alu_s = ALU_S_W'(ALU_ADD);
                    OP_SUB:  w_alu_s = ALU_S_W'(ALU_SUB);
                    OP_AND:  w_alu_s = ALU_S_W'(ALU_AND);
                    OP_OR:   w_alu_s = ALU_S_W'(ALU_OR);
                    default: w_alu_s = ALU_S_W'(ALU_PASS_A);
                endcase
                w_next = S_FETCH;
            end
            S_JMP: begin
                w_pc_ld = 1'b1;
                w_next  = S_FETCH;
            end
            S_BRZ: begin
                // Not-taken branches rely on the increment already done in DECODE.
                w_rf_a_addr = i_ir[11:8];
                w_alu_s     = ALU_S_W'(ALU_PASS_A);
                w_pc_ld     = i_alu_z;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (i_resume) begin
                    w_next = S_FETCH;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    // Reset forces every output low combinationally so nothing leaks out while
    // reset is held, including the INIT-state PC clear.
    assign o_pc_clr    = i_reset ? 1'b0 : w_pc_clr;
    assign o_pc_ld     = i_reset ? 1'b0 : w_pc_ld;
    assign o_pc_addr   = i_reset ? '0   : PC_W'(i_ir[7:0]);
    assign o_pc_ic     = i_reset ? 1'b0 : w_pc_ic;
    assign o_ir_ld     = i_reset ? 1'b0 : w_ir_ld;
    assign o_d_addr    = i_reset ? '0   : w_d_addr;
    assign o_d_wr      = i_reset ? 1'b0 : w_d_wr;
    assign o_rf_s      = i_reset ? 1'b0 : w_rf_s;
    assign o_rf_w_en   = i_reset ? 1'b0 : w_rf_w_en;
    assign o_rf_a_addr = i_reset ? '0   : w_rf_a_addr;
    assign o_rf_b_addr = i_reset ? '0   : w_rf_b_addr;
    assign o_rf_w_addr = i_reset ? '0   : w_rf_w_addr;
    assign o_alu_s     = i_reset ? '0   : w_alu_s;
    assign o_halted    = i_reset ? 1'b0 : w_halted;
    assign o_illegal   = i_reset ? 1'b0 : w_illegal;
    assign o_state     = i_reset ? 4'd0 : r_state;

endmodule

// File: tb/tb_param_control_unit.sv
// Testbench for param_control_unit. Main instance: LOAD_LAT=3, skip mode.
// Second instance: LOAD_LAT=1, trap mode, used for the illegal-trap scenario.
module tb_param_control_unit;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_ld;
        logic [7:0] pc_addr;
        logic       pc_ic;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic       rf_w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rw;
        logic [3:0] alu_s;
        logic       halted;
        logic       illegal;
        logic [3:0] st;
    } out_t;

    typedef struct {
        out_t e;
        logic res;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        rst0 = 1'b1;
    logic [15:0] ir0  = 16'h0000;
    logic        z0   = 1'b0;
    logic        res0 = 1'b0;
    logic        a_pc_clr, a_pc_ld, a_pc_ic, a_ir_ld, a_d_wr, a_rf_s, a_rf_w_en, a_halted, a_illegal;
    logic [7:0]  a_pc_addr, a_d_addr;
    logic [3:0]  a_ra, a_rb, a_rw, a_alu_s, a_st;
    out_t        act0;

    // trap instance signals
    logic        rst1 = 1'b1;
    logic [15:0] ir1  = 16'h0000;
    logic        z1   = 1'b0;
    logic        res1 = 1'b0;
    logic        b_pc_clr, b_pc_ld, b_pc_ic, b_ir_ld, b_d_wr, b_rf_s, b_rf_w_en, b_halted, b_illegal;
    logic [7:0]  b_pc_addr, b_d_addr;
    logic [3:0]  b_ra, b_rb, b_rw, b_alu_s, b_st;
    out_t        act1;

    int n_vec = 0;
    int n_bad = 0;

    param_control_unit #(.LOAD_LAT(3), .PC_W(8), .ALU_S_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .i_clock(clk), .i_reset(rst0), .i_ir(ir0), .i_alu_z(z0), .i_resume(res0),
        .o_pc_clr(a_pc_clr), .o_pc_ld(a_pc_ld), .o_pc_addr(a_pc_addr), .o_pc_ic(a_pc_ic),
        .o_ir_ld(a_ir_ld), .o_d_addr(a_d_addr), .o_d_wr(a_d_wr), .o_rf_s(a_rf_s),
        .o_rf_w_en(a_rf_w_en), .o_rf_a_addr(a_ra), .o_rf_b_addr(a_rb), .o_rf_w_addr(a_rw),
        .o_alu_s(a_alu_s), .o_halted(a_halted), .o_illegal(a_illegal), .o_state(a_st)
    );

    param_control_unit #(.LOAD_LAT(1), .PC_W(8), .ALU_S_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .i_clock(clk), .i_reset(rst1), .i_ir(ir1), .i_alu_z(z1), .i_resume(res1),
        .o_pc_clr(b_pc_clr), .o_pc_ld(b_pc_ld), .o_pc_addr(b_pc_addr), .o_pc_ic(b_pc_ic),
        .o_ir_ld(b_ir_ld), .o_d_addr(b_d_addr), .o_d_wr(b_d_wr), .o_rf_s(b_rf_s),
        .o_rf_w_en(b_rf_w_en), .o_rf_a_addr(b_ra), .o_rf_b_addr(b_rb), .o_rf_w_addr(b_rw),
        .o_alu_s(b_alu_s), .o_halted(b_halted), .o_illegal(b_illegal), .o_state(b_st)
    );

    assign act0 = {a_pc_clr, a_pc_ld, a_pc_addr, a_pc_ic, a_ir_ld, a_d_addr, a_d_wr, a_rf_s,
                   a_rf_w_en, a_ra, a_rb, a_rw, a_alu_s, a_halted, a_illegal, a_st};
    assign act1 = {b_pc_clr, b_pc_ld, b_pc_addr, b_pc_ic, b_ir_ld, b_d_addr, b_d_wr, b_rf_s,
                   b_rf_w_en, b_ra, b_rb, b_rw, b_alu_s, b_halted, b_illegal, b_st};

    // Idle view of a state: only STATE and the always-present jump target.
    function automatic out_t idle(input logic [3:0] st, input logic [15:0] ir);
        out_t o;
        o         = '0;
        o.st      = st;
        o.pc_addr = ir[7:0];
        return o;
    endfunction

    // Reference model: per-cycle expectation list for one instruction, from FETCH
    // through its last execute cycle. Resume is random outside HALT.
    task automatic run_instr(input string name, input logic [15:0] ir_new,
                             input logic z, input int hold);
        step_t      q[$];
        step_t      s;
        logic [3:0] op;
        op = ir_new[15:12];

        s.e = idle(4'd1, ir0); s.e.ir_ld = 1'b1; s.res = 1'($urandom); q.push_back(s);
        s.e = idle(4'd2, ir_new); s.e.pc_ic = 1'b1; s.res = 1'($urandom);
        s.e.illegal = (op >= 4'h9 && op <= 4'hE);
        q.push_back(s);

        if (op == 4'h1) begin
            for (int i = 0; i <= 3; i++) begin
                s.e = idle((i < 3) ? 4'd3 : 4'd4, ir_new);
                s.e.d_addr = ir_new[11:4]; s.e.rf_s = 1'b1; s.e.rw = ir_new[3:0];
                s.e.rf_w_en = (i == 3); s.res = 1'($urandom);
                q.push_back(s);
            end
        end else if (op == 4'h2) begin
            s.e = idle(4'd5, ir_new); s.e.d_addr = ir_new[7:0]; s.e.ra = ir_new[11:8];
            s.e.d_wr = 1'b1; s.res = 1'($urandom); q.push_back(s);
        end else if (op >= 4'h3 && op <= 4'h6) begin
            s.e = idle(4'd6, ir_new); s.e.ra = ir_new[11:8]; s.e.rb = ir_new[7:4];
            s.e.rw = ir_new[3:0]; s.e.rf_w_en = 1'b1; s.e.alu_s = op - 4'd2;
            s.res = 1'($urandom); q.push_back(s);
        end else if (op == 4'h7) begin
            s.e = idle(4'd7, ir_new); s.e.pc_ld = 1'b1; s.res = 1'($urandom); q.push_back(s);
        end else if (op == 4'h8) begin
            s.e = idle(4'd8, ir_new); s.e.ra = ir_new[11:8]; s.e.pc_ld = z;
            s.res = 1'($urandom); q.push_back(s);
        end else if (op == 4'hF) begin
            for (int i = 0; i < hold; i++) begin
                s.e = idle(4'd9, ir_new); s.e.halted = 1'b1; s.res = (i == hold - 1);
                q.push_back(s);
            end
        end

        z0 = z;
        foreach (q[k]) begin
            if (k == 1) ir0 = ir_new;
            res0 = q[k].res;
            @(negedge clk);
            n_vec++;
            if (act0 !== q[k].e) begin
                n_bad++;
                $display("FAIL %s ir=%h step %0d: got %h expected %h", name, ir_new, k, act0, q[k].e);
            end
            @(posedge clk); #1;
        end
        res0 = 1'b0;
    endtask

    task automatic test_reset();
        out_t e;
        #3;
        n_vec++;
        if (act0 !== out_t'(0)) begin
            n_bad++; $display("FAIL reset_hold: got %h expected 0", act0);
        end
        @(negedge clk); #1;
        rst0 = 1'b0;
        #1;
        e = idle(4'd0, ir0); e.pc_clr = 1'b1;
        n_vec++;
        if (act0 !== e) begin
            n_bad++; $display("FAIL reset_init: got %h expected %h", act0, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_instr("add", 16'h3125, 1'b0, 1);
    endtask

    task automatic test_load();
        run_instr("load", 16'h1A47, 1'b1, 1);
    endtask

    task automatic test_brz();
        run_instr("brz_taken", 16'h8300, 1'b1, 1);
        run_instr("brz_not_taken", 16'h8300, 1'b0, 1);
    endtask

    task automatic test_halt();
        run_instr("halt", 16'hF000, 1'b0, 11);
    endtask

    task automatic test_illegal_skip();
        run_instr("illegal_skip", 16'hB000, 1'b0, 1);
    endtask

    task automatic test_illegal_trap();
        out_t e;
        n_vec++;
        if (act1 !== out_t'(0)) begin
            n_bad++; $display("FAIL trap_reset: got %h expected 0", act1);
        end
        @(negedge clk); #1;
        rst1 = 1'b0;
        #1;
        e = idle(4'd0, 16'h0000); e.pc_clr = 1'b1;
        n_vec++;
        if (act1 !== e) begin
            n_bad++; $display("FAIL trap_init: got %h expected %h", act1, e);
        end
        @(posedge clk); #1;
        e = idle(4'd1, 16'h0000); e.ir_ld = 1'b1;
        n_vec++;
        if (act1 !== e) begin
            n_bad++; $display("FAIL trap_fetch: got %h expected %h", act1, e);
        end
        @(posedge clk); #1;
        ir1 = 16'hB000;
        #1;
        e = idle(4'd2, 16'hB000); e.pc_ic = 1'b1; e.illegal = 1'b1;
        n_vec++;
        if (act1 !== e) begin
            n_bad++; $display("FAIL trap_decode: got %h expected %h", act1, e);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            e = idle(4'd9, 16'hB000); e.halted = 1'b1;
            n_vec++;
            if (act1 !== e) begin
                n_bad++; $display("FAIL trap_halt cycle %0d: got %h expected %h", i, act1, e);
            end
        end
        res1 = 1'b1;
        @(posedge clk); #1;
        res1 = 1'b0;
        e = idle(4'd1, 16'hB000); e.ir_ld = 1'b1;
        n_vec++;
        if (act1 !== e) begin
            n_bad++; $display("FAIL trap_resume: got %h expected %h", act1, e);
        end
    endtask

    task automatic test_reset_mid_load();
        out_t e;
        @(posedge clk); #1;          // FETCH -> DECODE
        ir0 = 16'h1A47;
        @(posedge clk); #1;          // now in first LOAD cycle
        e = idle(4'd3, 16'h1A47); e.d_addr = 8'hA4; e.rf_s = 1'b1; e.rw = 4'h7;
        n_vec++;
        if (act0 !== e) begin
            n_bad++; $display("FAIL midload_pre: got %h expected %h", act0, e);
        end
        #2;
        rst0 = 1'b1;
        #1;
        n_vec++;
        if (act0 !== out_t'(0)) begin
            n_bad++; $display("FAIL midload_async: got %h expected 0", act0);
        end
        @(posedge clk); #1;
        n_vec++;
        if (act0 !== out_t'(0)) begin
            n_bad++; $display("FAIL midload_held: got %h expected 0", act0);
        end
        @(negedge clk); #1;
        rst0 = 1'b0;
        #1;
        e = idle(4'd0, ir0); e.pc_clr = 1'b1;
        n_vec++;
        if (act0 !== e) begin
            n_bad++; $display("FAIL midload_init: got %h expected %h", act0, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] ir;
        for (int i = 0; i < 150; i++) begin
            ir = 16'($urandom);
            run_instr("random", ir, 1'($urandom), int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_store", 16'h2C3D, 1'b0, 1);
        run_instr("b2b_jmp", 16'h70E1, 1'b1, 1);
        run_instr("b2b_sub", 16'h4ABC, 1'b0, 1);
        run_instr("b2b_and", 16'h5123, 1'b0, 1);
        run_instr("b2b_or", 16'h6FED, 1'b1, 1);
        run_instr("b2b_noop", 16'h0055, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load();
        test_brz();
        test_halt();
        test_illegal_skip();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        test_illegal_trap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/param_control_unit.md
# param_control_unit

Parametrised multicycle control unit for the 16-bit CPU. It sequences fetch, decode and execute for each instruction in the instruction register, and drives the program counter, data memory, register file and ALU select lines of the datapath. Compared with the first generation it adds a configurable load latency, conditional branch on the ALU zero flag, an unconditional PC-load jump, a HALT that can be resumed, and selectable illegal-opcode handling.

## Interface
Parameters:
- LOAD_LAT, 1: data-memory read latency in cycles; legal range 1..15.
- PC_W, 8: program counter width, ≥ 8.
- ALU_S_W, 4: ALU select width, ≥ 3.
- TRAP_ON_ILLEGAL, 0: illegal-opcode mode. 0 skips the instruction; 1 enters HALT.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- IR  in  16  current instruction. Stable from the cycle after IR_LD until the next IR_LD.
- ALU_Z  in  1  ALU zero flag, combinational from the current ALU inputs.
- Resume  in  1  leaves HALT.
- PC_CLR  out  1  clear PC.
- PC_LD  out  1  load PC from PC_ADDR.
- PC_ADDR  out  PC_W  jump target: IR[7:0] zero-extended.
- PC_IC  out  1  increment PC.
- IR_LD  out  1  load IR from instruction memory at PC.
- D_ADDR  out  8  data memory address.
- D_WR  out  1  data memory write enable.
- RF_S  out  1  register-file write mux: 1 selects memory, 0 selects ALU.
- RF_W_EN  out  1  register-file write enable.
- RF_A_ADDR, RF_B_ADDR, RF_W_ADDR  out  4 each  register-file addresses.
- ALU_S  out  ALU_S_W  ALU function select.
- Halted  out  1  high while in HALT.
- Illegal  out  1  one-cycle pulse in DECODE when the opcode is undefined.
- STATE  out  4  current state encoding, for debug.

## Operation
- Opcodes in IR[15:12]:
  - NOOP 0x0, LOAD 0x1, STORE 0x2, ADD 0x3, SUB 0x4, AND 0x5, OR 0x6, JMP 0x7, BRZ 0x8, HALT 0xF.
  - 0x9–0xE are illegal.
- ALU_S codes: PASS_A 0, ADD 1, SUB 2, AND 3, OR 4, zero-extended to ALU_S_W.
- State register is the only state besides the load counter. All outputs are combinational from state and IR.
- Any output not listed for a state is 0.
- State encodings and behaviour:
  - INIT (0): PC_CLR=1 → FETCH.
  - FETCH (1): IR_LD=1 → DECODE.
  - DECODE (2): PC_IC=1. Next state by opcode:
    - NOOP → FETCH.
    - LOAD → LOAD, with counter set to LOAD_LAT−1.
    - STORE → STORE.
    - ADD/SUB/AND/OR → ALU.
    - JMP → JMP; BRZ → BRZ; HALT → HALT.
    - Illegal: Illegal=1; → HALT if TRAP_ON_ILLEGAL=1, else → FETCH.
  - LOAD (3): D_ADDR=IR[11:4], RF_S=1, RF_W_ADDR=IR[3:0]. Counter decrements each cycle; when counter=0 → LOAD_WB. Total LOAD_LAT cycles.
  - LOAD_WB (4): LOAD outputs plus RF_W_EN=1 → FETCH.
  - STORE (5): D_ADDR=IR[7:0], RF_A_ADDR=IR[11:8], D_WR=1 → FETCH.
  - ALU (6): RF_A_ADDR=IR[11:8], RF_B_ADDR=IR[7:4], RF_W_ADDR=IR[3:0], RF_W_EN=1, ALU_S per opcode → FETCH.
  - JMP (7): PC_LD=1 → FETCH. PC_ADDR is driven in every state.
  - BRZ (8): RF_A_ADDR=IR[11:8], ALU_S=PASS_A; PC_LD=ALU_Z → FETCH. The DECODE increment stands when not taken.
  - HALT (9): Halted=1. Resume=1 → FETCH; otherwise stay in HALT.
- Encodings 10–15 unreachable; if entered, → INIT.

## Timing
- Reset high: state=INIT, counter=0, every output forced to 0, including PC_CLR and STATE.
- First rising edge after Reset falls: INIT outputs (PC_CLR=1) are already visible; that edge moves the state to FETCH.
- Reset mid-instruction: outputs go to 0 immediately and the state is lost. No partial write is issued after assertion.
- Cycles per instruction, FETCH through the last execute cycle:
  - NOOP / illegal (skip mode): 2.
  - STORE, ALU, JMP, BRZ: 3.
  - LOAD: 3+LOAD_LAT.
- PC_LD and PC_IC are never high in the same cycle.
- D_WR and RF_W_EN are never high in the same cycle.
- Resume is sampled only in HALT; a Resume pulse outside HALT has no effect.

## Test plan
- Reset release, then IR=0x3125 (ADD): STATE sequence 0,1,2,6,1. In state 6: RF_A=1, RF_B=2, RF_W=5, ALU_S=1, RF_W_EN=1.
- LOAD_LAT=3, IR=0x1A47: LOAD held exactly 3 cycles with D_ADDR=0xA4, RF_S=1, RF_W_EN=0; then one LOAD_WB cycle with RF_W_EN=1, RF_W_ADDR=7.
- IR=0x8300 (BRZ): with ALU_Z=1, PC_LD=1 and PC_ADDR=0x00. Repeat with ALU_Z=0: PC_LD=0, and PC_IC was 1 in DECODE.
- IR=0xF000 (HALT): Halted holds for 10 cycles with Resume=0. Resume=1 → FETCH on the next edge; Halted=0.
- IR=0xB000 (illegal): Illegal pulses one cycle. With TRAP_ON_ILLEGAL=0 → FETCH; with TRAP_ON_ILLEGAL=1 → HALT.
- Reset asserted asynchronously mid-LOAD, between clock edges: all outputs 0 within the same cycle, STATE=0. After release, the sequence restarts at INIT.
